// File: rtl/alut_apb_init16.sv
// rtl/alut_apb_init16.sv - APB master sequencing single reads/writes and masked read-polls
module alut_apb_init16 #(
  parameter int POLL_MAX = 16,
  parameter int POLL_GAP = 4
) (
  input  logic        pclk16,
  input  logic        n_p_reset16,
  input  logic        req_valid16,
  output logic        req_ready16,
  input  logic        req_write16,
  input  logic        req_poll16,
  input  logic [6:0]  req_addr16,
  input  logic [31:0] req_wdata16,
  output logic        psel16,
  output logic        penable16,
  output logic        pwrite16,
  output logic [6:0]  paddr16,
  output logic [31:0] pwdata16,
  input  logic [31:0] prdata16,
  output logic        rsp_valid16,
  output logic [31:0] rsp_rdata16,
  output logic        rsp_timeout16,
  output logic        busy16
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } state_t;

  localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);
  localparam logic [3:0] GAP_LAST   = 4'(POLL_GAP - 1);

  state_t      state;
  state_t      state_nxt;
  logic        wr_q;
  logic        poll_q;
  logic [6:0]  addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  count_q;
  logic [3:0]  gap_q;
  logic [31:0] rdata_q;
  logic        timeout_q;

  logic        accept;
  logic [7:0]  count_inc;
  logic        poll_hit;
  logic        xfer_done;

  assign accept    = req_valid16 && (state == ST_IDLE);
  assign count_inc = count_q + 8'd1;
  // wdata_q doubles as the poll mask; a zero mask therefore hits on the first read
  assign poll_hit  = ((prdata16 & wdata_q) == 32'd0);
  assign xfer_done = !poll_q || poll_hit || (count_inc == POLL_MAX_C);

  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid16) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = xfer_done ? ST_RESP : ST_GAP;
      ST_GAP:    if (gap_q == GAP_LAST) state_nxt = ST_SETUP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk16 or negedge n_p_reset16) begin
    if (!n_p_reset16) begin
      wr_q      <= 1'b0;
      poll_q    <= 1'b0;
      addr_q    <= 7'd0;
      wdata_q   <= 32'd0;
      count_q   <= 8'd0;
      gap_q     <= 4'd0;
      rdata_q   <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= req_write16;
        poll_q  <= req_poll16 && !req_write16;
        addr_q  <= req_addr16;
        wdata_q <= req_wdata16;
        count_q <= 8'd0;
      end
      if (state == ST_ACCESS) begin
        count_q <= count_inc;
        gap_q   <= 4'd0;
        // response registers only move on the final read so they stay stable between responses
        if (xfer_done) begin
          rdata_q   <= wr_q ? 32'd0 : prdata16;
          timeout_q <= poll_q && !poll_hit;
        end
      end
      if (state == ST_GAP) begin
        gap_q <= gap_q + 4'd1;
      end
    end
  end

  assign req_ready16   = (state == ST_IDLE);
  assign busy16        = (state != ST_IDLE);
  assign psel16        = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable16     = (state == ST_ACCESS);
  assign pwrite16      = wr_q;
  assign paddr16       = addr_q;
  assign pwdata16      = wr_q ? wdata_q : 32'd0;
  assign rsp_valid16   = (state == ST_RESP);
  assign rsp_rdata16   = rdata_q;
  assign rsp_timeout16 = timeout_q;

endmodule

// File: tb/tb_alut_apb_init16.sv
// tb/tb_alut_apb_init16.sv - scoreboard bench for alut_apb_init16 with randomized requests
module tb_alut_apb_init16;

  localparam int POLL_MAX_T = 3;
  localparam int POLL_GAP_T = 4;

  logic        pclk16 = 1'b0;
  logic        n_p_reset16 = 1'b0;
  logic        req_valid16 = 1'b0;
  logic        req_ready16;
  logic        req_write16 = 1'b0;
  logic        req_poll16 = 1'b0;
  logic [6:0]  req_addr16 = 7'd0;
  logic [31:0] req_wdata16 = 32'd0;
  logic        psel16;
  logic        penable16;
  logic        pwrite16;
  logic [6:0]  paddr16;
  logic [31:0] pwdata16;
  logic [31:0] prdata16 = 32'd0;
  logic        rsp_valid16;
  logic [31:0] rsp_rdata16;
  logic        rsp_timeout16;
  logic        busy16;

  alut_apb_init16 #(.POLL_MAX(POLL_MAX_T), .POLL_GAP(POLL_GAP_T)) dut (
    .pclk16(pclk16), .n_p_reset16(n_p_reset16),
    .req_valid16(req_valid16), .req_ready16(req_ready16),
    .req_write16(req_write16), .req_poll16(req_poll16),
    .req_addr16(req_addr16), .req_wdata16(req_wdata16),
    .psel16(psel16), .penable16(penable16), .pwrite16(pwrite16),
    .paddr16(paddr16), .pwdata16(pwdata16), .prdata16(prdata16),
    .rsp_valid16(rsp_valid16), .rsp_rdata16(rsp_rdata16),
    .rsp_timeout16(rsp_timeout16), .busy16(busy16)
  );

  always #5 pclk16 = ~pclk16;

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] pwd;
    logic [31:0] rdata;
    bit          to;
    int          reads;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] cand[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // reference: apply the poll rules directly to the candidate read values
  task automatic issue(input bit wr, input bit poll, input logic [6:0] addr,
                       input logic [31:0] wd, input bit hold, output int waited);
    exp_t e;
    e.wr = wr; e.addr = addr; e.pwd = wr ? wd : 32'd0; e.to = 0; e.reads = 1; e.rdata = 32'd0;
    if (!wr && !poll) begin
      e.rdata = cand[0];
      rd_q.push_back(cand[0]);
    end else if (!wr) begin
      for (int k = 0; k < POLL_MAX_T; k++) begin
        rd_q.push_back(cand[k]);
        e.reads = k + 1;
        e.rdata = cand[k];
        if ((cand[k] & wd) == 32'd0) break;
        if (k + 1 == POLL_MAX_T) e.to = 1;
      end
    end
    e.lat = 3 + (e.reads - 1) * (2 + POLL_GAP_T);
    exp_q.push_back(e);
    req_valid16 = 1'b1; req_write16 = wr; req_poll16 = poll;
    req_addr16 = addr; req_wdata16 = wd;
    waited = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge pclk16);
      waited++;
      if (req_ready16) break;
    end
    chk("accept_ready", 32'(req_ready16), 32'd1);
    @(posedge pclk16);
    #1;
    if (!hold) req_valid16 = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500; i++) begin
      @(negedge pclk16);
      if (exp_q.size() == 0) break;
    end
    chk("done_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge pclk16);
    #1;
  endtask

  task automatic gen_cand(input logic [31:0] mask);
    int hit;
    logic [31:0] v;
    hit = $urandom_range(1, POLL_MAX_T + 1);
    cand.delete();
    for (int k = 1; k <= POLL_MAX_T; k++) begin
      v = $urandom;
      if (mask != 32'd0) begin
        if (k < hit) v = v | (mask & (~mask + 32'd1));
        else if (k == hit) v = v & ~mask;
      end
      cand.push_back(v);
    end
  endtask

  // APB slave: present read data during ACCESS so it is stable at the ending edge
  always @(negedge pclk16) begin
    if (n_p_reset16 && psel16 && penable16 && !pwrite16) begin
      if (rd_q.size() > 0) prdata16 = rd_q.pop_front();
      else prdata16 = $urandom;
    end
  end

  int          cyc = 0;
  int          acc_cyc = 0;
  int          xfers = 0;
  logic [31:0] last_rdata = 32'd0;
  logic        last_to = 1'b0;

  always @(negedge pclk16) begin
    exp_t e;
    if (!n_p_reset16) begin
      last_rdata = 32'd0;
      last_to = 1'b0;
      xfers = 0;
    end else begin
      cyc++;
      if (req_valid16 && req_ready16) begin
        chk("accept_expected", 32'(exp_q.size() != 0), 32'd1);
        acc_cyc = cyc;
        xfers = 0;
      end
      if (psel16) begin
        chk("apb_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("paddr", 32'(paddr16), 32'(exp_q[0].addr));
          chk("pwrite", 32'(pwrite16), 32'(exp_q[0].wr));
          chk("pwdata", pwdata16, exp_q[0].pwd);
        end
        if (penable16) xfers++;
      end
      if (rsp_valid16) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata16, e.rdata);
          chk("rsp_timeout", 32'(rsp_timeout16), 32'(e.to));
          chk("apb_reads", 32'(xfers), 32'(e.reads));
          chk("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
        last_rdata = rsp_rdata16;
        last_to = rsp_timeout16;
      end else begin
        chk("rdata_hold", rsp_rdata16, last_rdata);
        chk("timeout_hold", 32'(rsp_timeout16), 32'(last_to));
      end
    end
  end

  initial begin
    int w;
    int kind;
    logic [31:0] mask;
    #2;
    chk("rst_ready", 32'(req_ready16), 32'd1);
    chk("rst_psel", 32'(psel16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid16), 32'd0);
    chk("rst_rdata", rsp_rdata16, 32'd0);
    repeat (3) @(posedge pclk16);
    @(negedge pclk16);
    n_p_reset16 = 1'b1;
    @(posedge pclk16);
    #1;

    cand.delete(); cand.push_back(32'h0);
    issue(1'b1, 1'b0, 7'h04, 32'h0000_1234, 1'b0, w);
    wait_done();
    cand.delete(); cand.push_back(32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 7'h30, 32'h5555_AAAA, 1'b0, w);
    wait_done();
    cand.delete(); cand.push_back(32'h2); cand.push_back(32'hF); cand.push_back(32'h1);
    issue(1'b0, 1'b1, 7'h28, 32'h2, 1'b0, w);
    wait_done();
    cand.delete(); cand.push_back(32'h1); cand.push_back(32'h1); cand.push_back(32'h1);
    issue(1'b0, 1'b1, 7'h28, 32'hFFFF_FFFF, 1'b0, w);
    wait_done();
    cand.delete(); cand.push_back(32'hFFFF_FFFF); cand.push_back(32'h1); cand.push_back(32'h1);
    issue(1'b0, 1'b1, 7'h11, 32'h0, 1'b0, w);
    wait_done();

    cand.delete(); cand.push_back(32'h0);
    issue(1'b1, 1'b0, 7'h08, 32'hA5A5_0001, 1'b1, w);
    cand.delete(); cand.push_back(32'h1357_9BDF);
    issue(1'b0, 1'b0, 7'h0C, 32'h0, 1'b0, w);
    chk("b2b_accept_gap", 32'(w), 32'd4);
    wait_done();

    cand.delete(); cand.push_back(32'h0BAD_F00D);
    issue(1'b0, 1'b0, 7'h14, 32'h0, 1'b0, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk16);
      if (penable16) break;
    end
    #1;
    req_valid16 = 1'b1; req_write16 = 1'b1; req_addr16 = 7'h7F; req_wdata16 = 32'hFFFF_0000;
    @(negedge pclk16);
    #1;
    req_valid16 = 1'b0;
    wait_done();
    repeat (3) @(posedge pclk16);
    #1;

    cand.delete(); cand.push_back(32'hCAFE_0000);
    issue(1'b0, 1'b0, 7'h1C, 32'h0, 1'b0, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk16);
      if (penable16) break;
    end
    #2;
    n_p_reset16 = 1'b0;
    #1;
    chk("abort_psel", 32'(psel16), 32'd0);
    chk("abort_penable", 32'(penable16), 32'd0);
    chk("abort_ready", 32'(req_ready16), 32'd1);
    chk("abort_busy", 32'(busy16), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid16), 32'd0);
    chk("abort_paddr", 32'(paddr16), 32'd0);
    exp_q.delete();
    rd_q.delete();
    @(negedge pclk16);
    #2;
    n_p_reset16 = 1'b1;
    repeat (4) @(posedge pclk16);
    #1;
    cand.delete(); cand.push_back(32'h7777_8888);
    issue(1'b0, 1'b0, 7'h1C, 32'h0, 1'b0, w);
    wait_done();

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: mask = 32'h0;
        1: mask = 32'hFFFF_FFFF;
        default: mask = $urandom;
      endcase
      gen_cand(mask);
      issue(kind == 0, (kind == 2) || (kind == 0 && $urandom_range(0, 1) == 1),
            7'($urandom), (kind == 2) ? mask : $urandom, 1'b0, w);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alut_apb_init16.md
ALUT_APB_INIT16 -- requirements
Module: alut_apb_init16

Interface
REQ-001 The block SHALL have one clock (pclk16); reset n_p_reset16 SHALL be asynchronous, active-low.
REQ-002 The block SHALL provide parameters, one per line:
- POLL_MAX, default 16: maximum reads per poll request; legal 1-255.
- POLL_GAP, default 4: idle cycles between poll reads; legal 1-15.
REQ-003 The block SHALL provide these ports, one per line:
- pclk16  in  1  APB clock
- n_p_reset16  in  1  async active-low reset
- req_valid16  in  1  request offered
- req_ready16  out  1  request accepted when high with req_valid16
- req_write16  in  1  1=write, 0=read
- req_poll16  in  1  read-poll until masked bits clear; ignored when req_write16=1
- req_addr16  in  7  APB register address
- req_wdata16  in  32  write data; poll mask when req_poll16=1
- psel16  out  1  APB select
- penable16  out  1  APB enable
- pwrite16  out  1  APB direction
- paddr16  out  7  APB address
- pwdata16  out  32  APB write data
- prdata16  in  32  APB read data
- rsp_valid16  out  1  one-cycle completion pulse
- rsp_rdata16  out  32  read data; 0 for writes
- rsp_timeout16  out  1  poll ended without condition met; valid with rsp_valid16
- busy16  out  1  high in any state other than IDLE

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS, GAP, RESP.
REQ-005 req_ready16 SHALL be 1 only in IDLE; the block SHALL capture write, poll, addr and wdata on the clock edge where req_valid16 and req_ready16 are both 1, then enter SETUP.
REQ-006 SETUP SHALL drive psel16=1, penable16=0 for one cycle, then go to ACCESS.
REQ-007 ACCESS SHALL drive psel16=1, penable16=1 for exactly one cycle; no wait states; prdata16 SHALL be sampled on the edge that ends ACCESS.
REQ-008 paddr16, pwrite16 and pwdata16 SHALL hold constant across SETUP and ACCESS.
REQ-009 pwdata16 SHALL be 0 for reads; psel16 and penable16 SHALL be 0 in IDLE, GAP and RESP.
REQ-010 A plain read or write SHALL go ACCESS->RESP.
REQ-011 RESP SHALL pulse rsp_valid16 for one cycle and then return to IDLE; accept-edge to rsp_valid16 SHALL be exactly 3 cycles.
REQ-012 For a poll, the block SHALL count completed reads in an 8-bit counter cleared at accept.
REQ-013 After each poll read:
- if (prdata16 & mask)==0: go to RESP, rsp_timeout16=0.
- else if count==POLL_MAX: go to RESP, rsp_timeout16=1.
- else: go to GAP.
REQ-014 GAP SHALL last exactly POLL_GAP cycles, then go to SETUP with the same address.
REQ-015 rsp_rdata16 SHALL hold the last sampled prdata16 for reads and polls, and 0 for writes; it and rsp_timeout16 SHALL stay stable until the next RESP.
REQ-016 A poll with mask 0 SHALL complete after one read with rsp_timeout16=0.
REQ-017 req_valid16 asserted while busy16=1 SHALL be ignored; it is not queued.

Reset
REQ-018 While n_p_reset16=0, all outputs SHALL be 0 except req_ready16=1, and the FSM SHALL be in IDLE, independent of pclk16.
REQ-019 Reset asserted mid-transfer SHALL drop psel16 and penable16 immediately; no rsp_valid16 SHALL follow for the aborted request.

Verification
REQ-020 Write: addr 0x04, data 0x0000_1234 accepted at cycle 0 -> cycle 1 psel=1, pen=0; cycle 2 psel=1, pen=1, pwrite=1, paddr=0x04, pwdata=0x1234; cycle 3 rsp_valid=1, rsp_rdata=0.
REQ-021 Read: addr 0x30, prdata=0xDEAD_BEEF in ACCESS -> cycle 3 rsp_valid=1, rsp_rdata=0xDEADBEEF, pwdata=0 during transfer.
REQ-022 Poll: addr 0x28, mask 0x2, prdata bit1 = 1,1,0 on successive reads -> 3 reads, each separated by 4 GAP cycles, then rsp_valid, rsp_timeout=0, rsp_rdata bit1=0.
REQ-023 Poll timeout: POLL_MAX=3, mask 0xFFFF_FFFF, prdata=1 always -> exactly 3 APB reads, then rsp_valid=1, rsp_timeout=1, rsp_rdata=1.
REQ-024 Back-to-back and busy: req_valid held high with two requests -> second accepted in the RESP+1 (IDLE) cycle; a request pulsed during ACCESS -> ignored, no extra transfer.
REQ-025 Reset in ACCESS of a read -> psel/penable=0 asynchronously, no rsp_valid; after release a new read completes normally in 3 cycles.
